// File: rtl/mantissa_aligner.sv
// -----------------------------------------------------------------------------
// mantissa_aligner
//
// Aligns the smaller-exponent mantissa of a floating-point add/sub operand
// pair to the larger one. An accepted operand set goes through a small FSM:
// the smaller mantissa is widened by three guard/round/sticky bits and shifted
// right one bit per clock, folding any bit that drops off into the sticky bit.
// Shifts of 27 or more skip the FSM loop and collapse straight to a sticky-only
// value, so the latency is shift_amt cycles for shifts 1..26 and zero
// otherwise. Every output comes from a register.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    operand set on ma/mb/big_sign/shift_amt/larger_exp is valid
//   in_ready    block is idle and can accept an operand set
//   ma, mb      24-bit mantissas (hidden bit included)
//   big_sign    1 when B has the larger exponent
//   shift_amt   exponent difference (unsigned)
//   larger_exp  the larger exponent, passed through to exp_out
//   out_valid   aligned result is valid
//   out_ready   consumer takes the result
//   m_large     larger-exponent mantissa, unshifted
//   m_small     aligned smaller mantissa, [2:0] = guard, round, sticky
//   exp_out     registered larger exponent
// -----------------------------------------------------------------------------
module mantissa_aligner (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  input  logic        big_sign,
  input  logic [7:0]  shift_amt,
  input  logic [7:0]  larger_exp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] m_large,
  output logic [26:0] m_small,
  output logic [7:0]  exp_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Shifts at or beyond this width leave only the sticky bit.
  localparam logic [7:0] MaxShift = 8'd27;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [23:0] m_large_q;
  logic [26:0] m_small_q;
  logic [7:0]  exp_q;

  logic [23:0] small_mant_d;
  logic [26:0] small_shr_d;

  // NOTE: every signal assigned in an always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    small_mant_d = big_sign ? ma : mb;
    // One-bit right shift; bits 1 and 0 both fall into the sticky position.
    small_shr_d  = {1'b0, m_small_q[26:2], m_small_q[1] | m_small_q[0]};
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_large_q   <= 24'd0;
      m_small_q   <= 27'd0;
      exp_q       <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            m_large_q  <= big_sign ? mb : ma;
            exp_q      <= larger_exp;
            in_ready_q <= 1'b0;
            if (shift_amt == 8'd0) begin
              m_small_q   <= {small_mant_d, 3'b000};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (shift_amt < MaxShift) begin
              m_small_q <= {small_mant_d, 3'b000};
              cnt_q     <= shift_amt[4:0];
              state_q   <= SHIFT;
            end else begin
              m_small_q   <= {26'd0, |small_mant_d};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end

        SHIFT: begin
          m_small_q <= small_shr_d;
          cnt_q     <= cnt_q - 5'd1;
          // Counter is at least 1 here, so the decrement never wraps.
          if (cnt_q == 5'd1) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          // Result registers are left untouched until the next accept.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign m_large   = m_large_q;
  assign m_small   = m_small_q;
  assign exp_out   = exp_q;

endmodule

// File: tb/tb_mantissa_aligner.sv
// -----------------------------------------------------------------------------
// tb_mantissa_aligner
//
// Directed-vector bench for mantissa_aligner. Expected mantissas, exponents
// and latencies are hand-computed constants. Inputs change and outputs are
// sampled 1 ns after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_mantissa_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] ma;
  logic [23:0] mb;
  logic        big_sign;
  logic [7:0]  shift_amt;
  logic [7:0]  larger_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] m_large;
  logic [26:0] m_small;
  logic [7:0]  exp_out;

  int n_vec = 0;
  int n_bad = 0;

  mantissa_aligner dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ma         (ma),
    .mb         (mb),
    .big_sign   (big_sign),
    .shift_amt  (shift_amt),
    .larger_exp (larger_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .m_large    (m_large),
    .m_small    (m_small),
    .exp_out    (exp_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, keep in_valid high with junk while the block is
  // busy, then measure latency, check the result and complete the handshake.
  task automatic run_op(input string tag,
                        input logic [23:0] a, input logic [23:0] b,
                        input logic bs, input logic [7:0] sa, input logic [7:0] le,
                        input logic [23:0] e_large, input logic [26:0] e_small,
                        input int e_lat);
    int n;
    logic [31:0] r;
    check({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    ma = a; mb = b; big_sign = bs; shift_amt = sa; larger_exp = le;
    in_valid = 1'b1;
    tick();  // accepting edge E0
    check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    r = $urandom; ma = r[23:0];
    r = $urandom; mb = r[23:0];
    big_sign = ~bs; shift_amt = r[31:24]; larger_exp = ~le;
    n = 0;
    while (!out_valid && n < 64) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, 32'(n), 32'(e_lat));
    check({tag, ".m_large"}, 32'(m_large), 32'(e_large));
    check({tag, ".m_small"}, 32'(m_small), 32'(e_small));
    check({tag, ".exp_out"}, 32'(exp_out), 32'(le));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".out_valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready_post"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic saw_valid;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ma = '0; mb = '0; big_sign = 1'b0; shift_amt = '0; larger_exp = '0;
    tick();
    tick();
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.m_large",   32'(m_large),   32'd0);
    check("reset.m_small",   32'(m_small),   32'd0);
    check("reset.exp_out",   32'(exp_out),   32'd0);
    rst = 1'b0;
    tick();
    check("reset.in_ready",  32'(in_ready),  32'd1);

    // shift 0: plain widening of the smaller mantissa
    run_op("s0",   24'h800000, 24'hC00000, 1'b0, 8'd0,   8'h85, 24'h800000, 27'h6000000, 0);
    // shift 3, B larger, lost LSB lands in sticky
    run_op("s3",   24'h800001, 24'h900000, 1'b1, 8'd3,   8'h7F, 24'h900000, 27'h0800001, 3);
    // shortest loop
    run_op("s1",   24'h800000, 24'hFFFFFF, 1'b1, 8'd1,   8'h10, 24'hFFFFFF, 27'h2000000, 1);
    // guard/round set, sticky accumulates
    run_op("s5",   24'h000FFF, 24'h00001F, 1'b0, 8'd5,   8'h20, 24'h000FFF, 27'h0000007, 5);
    // longest loop: hidden bit ends up in the sticky position
    run_op("s26",  24'h123456, 24'h800000, 1'b0, 8'd26,  8'h90, 24'h123456, 27'h0000001, 26);
    // clamp path, non-zero mantissa
    run_op("s40",  24'h123456, 24'h800000, 1'b0, 8'd40,  8'h90, 24'h123456, 27'h0000001, 0);
    // first clamp value
    run_op("s27",  24'h000001, 24'hABCDEF, 1'b1, 8'd27,  8'hC3, 24'hABCDEF, 27'h0000001, 0);
    // clamp with an all-zero small mantissa
    run_op("s255", 24'hABCDEF, 24'h000000, 1'b0, 8'd255, 8'hFE, 24'hABCDEF, 27'h0000000, 0);

    // Back-pressure: result held while new data waits on in_valid.
    ma = 24'h111111; mb = 24'h222222; big_sign = 1'b1; shift_amt = 8'd0;
    larger_exp = 8'h44; in_valid = 1'b1;
    tick();
    ma = 24'h333333; mb = 24'h444444; big_sign = 1'b0; shift_amt = 8'd0;
    larger_exp = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.out_valid", 32'(out_valid), 32'd1);
      check("hold.in_ready",  32'(in_ready),  32'd0);
      check("hold.m_large",   32'(m_large),   32'h222222);
      check("hold.m_small",   32'(m_small),   32'h0888888);
      check("hold.exp_out",   32'(exp_out),   32'h44);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold.release_out_valid", 32'(out_valid), 32'd0);
    check("hold.release_in_ready",  32'(in_ready),  32'd1);
    check("hold.release_m_large",   32'(m_large),   32'h222222);
    tick();
    in_valid = 1'b0;
    check("hold.next_out_valid", 32'(out_valid), 32'd1);
    check("hold.next_m_large",   32'(m_large),   32'h333333);
    check("hold.next_m_small",   32'(m_small),   32'h2222220);
    check("hold.next_exp_out",   32'(exp_out),   32'h55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a 10-step shift.
    ma = 24'hFFFFFF; mb = 24'h800000; big_sign = 1'b0; shift_amt = 8'd10;
    larger_exp = 8'h99; in_valid = 1'b1;
    tick();  // E0
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.m_large",   32'(m_large),   32'd0);
    check("midrst.m_small",   32'(m_small),   32'd0);
    check("midrst.exp_out",   32'(exp_out),   32'd0);
    rst = 1'b0;
    tick();
    check("midrst.in_ready",  32'(in_ready),  32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      saw_valid = saw_valid | out_valid;
    end
    check("midrst.no_out_valid", 32'(saw_valid), 32'd0);
    run_op("post_rst", 24'h7FFFFF, 24'h000003, 1'b0, 8'd2, 8'h3C, 24'h7FFFFF, 27'h0000006, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mantissa_aligner.md
MANTISSA_ALIGNER -- requirements
Module: mantissa_aligner

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk is the only clock, and rst is sampled on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port in_valid, input, 1 bit: the operand set on the inputs is valid.
REQ-005 Port in_ready, output, 1 bit: the block can accept an operand set.
REQ-006 Port ma, input, 24 bits: mantissa of operand A, hidden bit included.
REQ-007 Port mb, input, 24 bits: mantissa of operand B, hidden bit included.
REQ-008 Port big_sign, input, 1 bit: exponent-compare borrow; 1 means B has the larger exponent.
REQ-009 Port shift_amt, input, 8 bits: exponent difference, unsigned magnitude.
REQ-010 Port larger_exp, input, 8 bits: the larger exponent.
REQ-011 Port out_valid, output, 1 bit: the aligned result is valid.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port m_large, output, 24 bits: mantissa with the larger exponent, unshifted.
REQ-014 Port m_small, output, 27 bits: aligned smaller mantissa; bits [2:0] are guard, round and sticky.
REQ-015 Port exp_out, output, 8 bits: registered copy of larger_exp.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 out_valid SHALL be 1 only in DONE.
REQ-019 Accept SHALL occur on a rising edge where state is IDLE and in_valid is 1.
REQ-020 On accept, operand selection SHALL follow big_sign:
- big_sign=1: m_large := mb and the small register := {ma,3'b000}.
- big_sign=0: m_large := ma and the small register := {mb,3'b000}.
REQ-021 On accept, exp_out := larger_exp.
REQ-022 On accept, the next state SHALL depend on shift_amt:
- shift_amt = 0: DONE.
- shift_amt in 1..26: SHIFT, with counter := shift_amt.
- shift_amt >= 27: DONE, with the small register := {26'b0, OR-reduce of the selected small mantissa}.
REQ-023 In SHIFT, each edge SHALL set small := {1'b0, small[26:2], small[1]|small[0]} and decrement the counter; the state SHALL go to DONE on the edge where the counter goes 1 -> 0.
REQ-024 Latency SHALL be fixed relative to the accepting edge E0:
- out_valid is first high after edge E0+N.
- N = shift_amt for shift_amt in 1..26.
- N = 0 for shift_amt = 0 and for shift_amt >= 27.
REQ-025 In DONE with out_ready=0, m_large, m_small, exp_out and out_valid SHALL hold stable.
REQ-026 DONE with out_ready=1 SHALL complete the transfer and return to IDLE on that edge; no new accept may occur on that same edge.
REQ-027 in_valid SHALL be ignored outside IDLE; inputs are sampled only on the accept edge.
REQ-028 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-029 The counter SHALL be 5 bits and SHALL never wrap; values 27..255 take the clamp path only.

Reset
REQ-030 While rst=1 at an edge, the state SHALL become IDLE, and this SHALL override any handshake.
REQ-031 On reset, out_valid := 0, m_large := 0, m_small := 0, exp_out := 0 and counter := 0.
REQ-032 in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-033 Reset asserted in SHIFT or DONE SHALL discard the in-flight operation; no out_valid pulse may follow.

Verification
REQ-034 Scenario: ma=0x800000, mb=0xC00000, big_sign=0, shift_amt=0, larger_exp=0x85 -> after E0, out_valid=1, m_large=0x800000, m_small=0x6000000, exp_out=0x85.
REQ-035 Scenario: ma=0x800001, mb=0x900000, big_sign=1, shift_amt=3 -> out_valid first high after E0+3, m_large=0x900000, m_small=0x0800001 (sticky set).
REQ-036 Scenario: mb=0x800000, big_sign=0, shift_amt=26 -> m_small=0x0000001 after E0+26; repeat with shift_amt=40 -> same m_small after E0.
REQ-037 Scenario: complete operation with out_ready held 0 for 5 cycles while in_valid=1 carries new data -> outputs stable, in_ready=0, and the new data is not accepted until one edge after out_ready=1.
REQ-038 Scenario: rst=1 two edges into shift_amt=10 -> IDLE, all outputs 0, no out_valid; a following accept with shift_amt=2 gives the correct result after E0+2.
